posit_round_encode: RTL and testbench



---
 rtl/posit_round_encode.sv | 160 ++++++++++++++++
 tb/tb_posit_round_encode.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_round_encode.sv
`timescale 1ns/1ps
// posit_round_encode
// Normalize / round / encode stage of the posit<8,0> multiplier. It takes
// the summed scale and the <2.10> fraction product from the multiply stage
// and produces a rounded 8-bit posit through a two-register pipeline.
//
// Ports
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   IN_VALID   upstream operand valid
//   IN_READY   stage can accept an operand this cycle
//   SIGN_C     result sign
//   ZERO_C     either operand is zero
//   NAR_C      either operand is NaR (wins over ZERO_C)
//   SCALE_C    summed scale, signed, -12..+12
//   FRAC_C     fraction product, unsigned <2.10>, [1.0, 4.0) when not special
//   OUT_VALID  POSIT_C valid
//   OUT_READY  downstream accepts POSIT_C
//   POSIT_C    encoded posit<8,0>
//
// Handshake: a word moves across a boundary on the edge where VALID and
// READY are both high. The producer holds VALID and its data steady until
// that edge. The output register loads when it is empty or being drained.
// Stage 1 loads when it is empty or the output register loads. IN_READY is
// the stage-1 load enable, so it follows OUT_READY combinationally.
module posit_round_encode (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        SIGN_C,
  input  logic        ZERO_C,
  input  logic        NAR_C,
  input  logic [4:0]  SCALE_C,
  input  logic [11:0] FRAC_C,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [7:0]  POSIT_C
);

  // Stage 1 registers
  logic              s1_v;
  logic              s1_sign;
  logic              s1_zero;
  logic              s1_nar;
  logic signed [5:0] s1_scale;
  logic [9:0]        s1_frac;   // fraction bits below the hidden 1
  logic              s1_sticky; // bit lost by the normalizing shift

  logic s1_load;
  logic s2_load;

  assign s2_load  = !OUT_VALID || OUT_READY;
  assign s1_load  = !s1_v || s2_load;
  assign IN_READY = s1_load;

  // Normalize: a product in [2,4) is shifted down one place.
  logic [9:0] norm_frac;
  logic       norm_sticky;
  logic [5:0] norm_scale;

  always_comb begin
    norm_frac   = FRAC_C[9:0];
    norm_sticky = 1'b0;
    norm_scale  = {SCALE_C[4], SCALE_C};
    if (FRAC_C[11]) begin
      norm_frac   = FRAC_C[10:1];
      norm_sticky = FRAC_C[0];
      norm_scale  = {SCALE_C[4], SCALE_C} + 6'd1;
    end
  end

  // Round/encode from the stage-1 registers
  logic        sat_hi;
  logic        sat_lo;
  logic [6:0]  ones_mask;
  logic [2:0]  k_neg;
  logic [6:0]  regime_val;
  logic [2:0]  sh;
  logic [16:0] body;
  logic [6:0]  mag_t;
  logic        guard;
  logic        stick;
  logic        inc;
  logic [7:0]  sum;
  logic [6:0]  mag_f;
  logic [7:0]  posit_nxt;

  always_comb begin
    sat_hi     = (s1_scale >= 6'sd6);
    sat_lo     = (s1_scale <= -6'sd7);
    // k+1 ones for k in 0..5
    ones_mask  = 7'h7F >> (3'd6 - s1_scale[2:0]);
    // -k for k in -6..-1 (low bits suffice in that range)
    k_neg      = 3'd0 - s1_scale[2:0];
    regime_val = 7'd1;
    sh         = 3'd0;
    if (!s1_scale[5]) begin
      regime_val = {ones_mask[5:0], 1'b0};
      sh         = 3'd5 - s1_scale[2:0];
    end else begin
      regime_val = 7'd1;
      sh         = 3'd6 - k_neg;
    end
    // Left-align regime+fraction so the regime starts at bit 16; the top 7
    // bits are the magnitude, then guard, then everything else is sticky.
    body  = {regime_val, s1_frac} << sh;
    mag_t = body[16:10];
    guard = body[9];
    stick = (|body[8:0]) | s1_sticky;
    inc   = guard & (stick | mag_t[0]);
    sum   = {1'b0, mag_t} + {7'd0, inc};
    mag_f = sum[7] ? 7'h7F : sum[6:0];
    if (sat_hi) begin
      mag_f = 7'h7F;
    end else if (sat_lo) begin
      mag_f = 7'h01;
    end
    posit_nxt = s1_sign ? (8'd0 - {1'b0, mag_f}) : {1'b0, mag_f};
    if (s1_zero) begin
      posit_nxt = 8'h00;
    end
    if (s1_nar) begin
      posit_nxt = 8'h80;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_v      <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_nar    <= 1'b0;
      s1_scale  <= 6'sd0;
      s1_frac   <= 10'd0;
      s1_sticky <= 1'b0;
      OUT_VALID <= 1'b0;
      POSIT_C   <= 8'h00;
    end else begin
      if (s1_load) begin
        s1_v <= IN_VALID;
        if (IN_VALID) begin
          s1_sign   <= SIGN_C;
          s1_zero   <= ZERO_C;
          s1_nar    <= NAR_C;
          s1_scale  <= norm_scale;
          s1_frac   <= norm_frac;
          s1_sticky <= norm_sticky;
        end
      end
      if (s2_load) begin
        OUT_VALID <= s1_v;
        if (s1_v) begin
          POSIT_C <= posit_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_round_encode.sv
`timescale 1ns/1ps
module tb_posit_round_encode;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic        SIGN_C;
  logic        ZERO_C;
  logic        NAR_C;
  logic [4:0]  SCALE_C;
  logic [11:0] FRAC_C;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  POSIT_C;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks %0d passed of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  posit_round_encode dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .SIGN_C    (SIGN_C),
    .ZERO_C    (ZERO_C),
    .NAR_C     (NAR_C),
    .SCALE_C   (SCALE_C),
    .FRAC_C    (FRAC_C),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .POSIT_C   (POSIT_C)
  );

  // ---------------- reference model ----------------
  // Value of a positive posit<8,0> pattern, in units of 2^-32.
  function automatic longint pval(input int p);
    int r, m, k, nrem, fr;
    bit run;
    r   = (p >> 6) & 1;
    m   = 0;
    run = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      if (run && (((p >> i) & 1) == r)) m++;
      else run = 1'b0;
    end
    k    = (r == 1) ? m - 1 : -m;
    nrem = 6 - m;
    if (nrem < 0) nrem = 0;
    fr   = p & ((1 << nrem) - 1);
    return longint'((1 << nrem) + fr) << (32 + k - nrem);
  endfunction

  // Nearest posit by value, ties to the even pattern, clamped to minpos/maxpos.
  function automatic logic [7:0] ref_posit(input bit s, input bit z, input bit n,
                                           input int sc, input int fr);
    longint v, dl, dh;
    int lo, m;
    if (n) return 8'h80;
    if (z) return 8'h00;
    v = longint'(fr) << (sc + 22);
    if (v >= pval(127)) m = 127;
    else if (v <= pval(1)) m = 1;
    else begin
      lo = 1;
      for (int p = 1; p < 127; p++) if (pval(p) <= v) lo = p;
      dl = v - pval(lo);
      dh = pval(lo + 1) - v;
      if (dl < dh) m = lo;
      else if (dh < dl) m = lo + 1;
      else m = (lo % 2 == 0) ? lo : lo + 1;
    end
    if (s) return 8'((256 - m) & 255);
    return 8'(m);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input bit s, input bit z, input bit n, input int sc, input int fr);
    SIGN_C  = s;
    ZERO_C  = z;
    NAR_C   = n;
    SCALE_C = 5'(sc);
    FRAC_C  = 12'(fr);
  endtask

  bit cur_s, cur_z, cur_n;
  int cur_sc, cur_fr;

  task automatic rand_op();
    cur_z  = ($urandom_range(0, 15) == 0);
    cur_n  = ($urandom_range(0, 31) == 0);
    cur_s  = $urandom_range(0, 1);
    cur_sc = int'($urandom_range(0, 24)) - 12;
    cur_fr = int'($urandom_range(12'h400, 12'hFFF));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N     = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    set_op(0, 0, 0, 0, 12'h400);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", OUT_VALID);
    else n_pass++;
    n_checks++;
    if (POSIT_C !== 8'h00) $display("FAIL reset_posit: got %h want 00", POSIT_C);
    else n_pass++;
    step();
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (IN_READY !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", IN_READY);
    else n_pass++;
    step();
  endtask

  task automatic test_latency();
    set_op(0, 0, 0, 0, 12'h400);
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b0) $display("FAIL lat_cycle0_valid: got %b want 0", OUT_VALID);
    else n_pass++;
    step();
    IN_VALID = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b0) $display("FAIL lat_cycle1_valid: got %b want 0", OUT_VALID);
    else n_pass++;
    step();
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b1 || POSIT_C !== 8'h40)
      $display("FAIL lat_cycle2_result: got v=%b %h want v=1 40", OUT_VALID, POSIT_C);
    else n_pass++;
    step();
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b0) $display("FAIL lat_drained: got %b want 0", OUT_VALID);
    else n_pass++;
  endtask

  localparam int ND = 18;
  bit         d_s [ND] = '{0,0,1,0,0,0,0,0,0,1,1,0,0,0,0,0,1,1};
  bit         d_z [ND] = '{0,0,0,0,0,0,0,0,0,1,1,0,0,0,0,0,0,0};
  bit         d_n [ND] = '{0,0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0};
  int         d_sc[ND] = '{0,0,0,0,0,0,6,-9,5,3,0,-6,-6,5,5,5,-12,0};
  int         d_fr[ND] = '{'h400,'h900,'h900,'h410,'h411,'h430,'h600,'h400,'hC00,'h500,
                           'h400,'h600,'h400,'h400,'h600,'h601,'h400,'h400};
  logic [7:0] d_ex[ND] = '{8'h40,8'h62,8'h9E,8'h40,8'h41,8'h42,8'h7F,8'h01,8'h7F,8'h00,
                           8'h80,8'h02,8'h01,8'h7E,8'h7E,8'h7F,8'hFF,8'hC0};

  task automatic test_directed();
    OUT_READY = 1'b1;
    for (int i = 0; i < ND; i++) begin
      set_op(d_s[i], d_z[i], d_n[i], d_sc[i], d_fr[i]);
      IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      step();
      @(negedge CLK);
      n_checks++;
      if (OUT_VALID !== 1'b1 || POSIT_C !== d_ex[i])
        $display("FAIL directed_%0d (scale %0d frac %h): got v=%b %h want v=1 %h",
                 i, d_sc[i], d_fr[i], OUT_VALID, POSIT_C, d_ex[i]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_backpressure();
    bit         bp_s [4];
    bit         bp_z [4];
    bit         bp_n [4];
    int         bp_sc[4];
    int         bp_fr[4];
    logic [7:0] exp_bp[4];
    int idx, got;
    bit acc;
    for (int i = 0; i < 4; i++) begin
      rand_op();
      bp_s[i] = cur_s; bp_z[i] = 1'b0; bp_n[i] = 1'b0;
      bp_sc[i] = cur_sc; bp_fr[i] = cur_fr;
      exp_bp[i] = ref_posit(bp_s[i], 1'b0, 1'b0, bp_sc[i], bp_fr[i]);
    end
    OUT_READY = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      IN_VALID = (idx < 4);
      if (idx < 4) set_op(bp_s[idx], bp_z[idx], bp_n[idx], bp_sc[idx], bp_fr[idx]);
      @(negedge CLK);
      if (cyc >= 2) begin
        n_checks++;
        if (IN_READY !== 1'b0) $display("FAIL bp_full_in_ready cyc%0d: got %b want 0", cyc, IN_READY);
        else n_pass++;
        n_checks++;
        if (OUT_VALID !== 1'b1 || POSIT_C !== exp_bp[0])
          $display("FAIL bp_hold cyc%0d: got v=%b %h want v=1 %h", cyc, OUT_VALID, POSIT_C, exp_bp[0]);
        else n_pass++;
      end
      acc = IN_VALID && IN_READY;
      step();
      if (acc) idx++;
    end
    n_checks++;
    if (idx !== 2) $display("FAIL bp_accept_count: got %0d want 2", idx);
    else n_pass++;
    got = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      OUT_READY = 1'b1;
      IN_VALID  = (idx < 4);
      if (idx < 4) set_op(bp_s[idx], bp_z[idx], bp_n[idx], bp_sc[idx], bp_fr[idx]);
      @(negedge CLK);
      if (cyc == 0) begin
        n_checks++;
        if (IN_READY !== 1'b1) $display("FAIL bp_resume_in_ready: got %b want 1", IN_READY);
        else n_pass++;
      end
      if (cyc < 4) begin
        n_checks++;
        if (OUT_VALID !== 1'b1) $display("FAIL bp_drain_valid cyc%0d: got %b want 1", cyc, OUT_VALID);
        else n_pass++;
      end
      if (OUT_VALID === 1'b1) begin
        n_checks++;
        if (got >= 4) $display("FAIL bp_extra_output: got %h want none", POSIT_C);
        else if (POSIT_C !== exp_bp[got])
          $display("FAIL bp_order_%0d: got %h want %h", got, POSIT_C, exp_bp[got]);
        else n_pass++;
        got++;
      end
      acc = IN_VALID && IN_READY;
      step();
      if (acc) idx++;
    end
    IN_VALID = 1'b0;
    n_checks++;
    if (got !== 4) $display("FAIL bp_output_count: got %0d want 4", got);
    else n_pass++;
  endtask

  task automatic test_random();
    int issued;
    bit acc, held_v;
    logic [7:0] held_val, exp_v;
    issued   = 0;
    held_v   = 1'b0;
    held_val = 8'h00;
    IN_VALID = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (issued >= 200 && exp_q.size() == 0 && !IN_VALID) break;
      if (!IN_VALID && issued < 200 && $urandom_range(0, 3) != 0) begin
        rand_op();
        set_op(cur_s, cur_z, cur_n, cur_sc, cur_fr);
        IN_VALID = 1'b1;
      end
      OUT_READY = (issued >= 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      if (held_v) begin
        n_checks++;
        if (OUT_VALID !== 1'b1 || POSIT_C !== held_val)
          $display("FAIL rnd_stall_stable cyc%0d: got v=%b %h want v=1 %h", cyc, OUT_VALID, POSIT_C, held_val);
        else n_pass++;
      end
      if (OUT_VALID === 1'b1 && OUT_READY) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rnd_unexpected_output: got %h want none", POSIT_C);
        else begin
          exp_v = exp_q.pop_front();
          if (POSIT_C !== exp_v) $display("FAIL rnd_result cyc%0d: got %h want %h", cyc, POSIT_C, exp_v);
          else n_pass++;
        end
      end
      held_v   = (OUT_VALID === 1'b1) && !OUT_READY;
      held_val = POSIT_C;
      acc = IN_VALID && IN_READY;
      if (acc) begin
        exp_q.push_back(ref_posit(cur_s, cur_z, cur_n, cur_sc, cur_fr));
        issued++;
      end
      step();
      if (acc) IN_VALID = 1'b0;
    end
    IN_VALID = 1'b0;
    n_checks++;
    if (issued !== 200 || exp_q.size() != 0)
      $display("FAIL rnd_completion: got issued=%0d pending=%0d want 200 and 0", issued, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic [7:0] exp_v;
    OUT_READY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_op();
      set_op(cur_s, 1'b0, 1'b0, cur_sc, cur_fr);
      IN_VALID = 1'b1;
      step();
    end
    IN_VALID = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (OUT_VALID !== 1'b0 || POSIT_C !== 8'h00)
      $display("FAIL midrst_clear: got v=%b %h want v=0 00", OUT_VALID, POSIT_C);
    else n_pass++;
    step();
    RST_N     = 1'b1;
    OUT_READY = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge CLK);
      n_checks++;
      if (OUT_VALID !== 1'b0) $display("FAIL midrst_spurious cyc%0d: got %b want 0", cyc, OUT_VALID);
      else n_pass++;
      step();
    end
    rand_op();
    set_op(cur_s, 1'b0, 1'b0, cur_sc, cur_fr);
    exp_v = ref_posit(cur_s, 1'b0, 1'b0, cur_sc, cur_fr);
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b1 || POSIT_C !== exp_v)
      $display("FAIL midrst_recover: got v=%b %h want v=1 %h", OUT_VALID, POSIT_C, exp_v);
    else n_pass++;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
